rom_arbiter: RTL and testbench
==============================

// Module: rom_arbiter
// PURPOSE
// - Shares the single combinational instruction ROM between IF-stage fetch and MEM-stage loads from code space.
// - Sits between the pipeline and the ROM; owns rom_ce/rom_addr.
// - Registers one grant per cycle, returns data in the grant cycle, and raises an IF stall request while IF waits.
// PARAMETERS
// - ADDR_W   12  ROM byte-address width (matches ROM addr port)
// - DATA_W   32  instruction/data word width
// PORTS
// - clk        in   1       clock; all state updates on posedge
// - rst        in   1       reset; synchronous, active-high
// - if_req     in   1       IF fetch request; held with if_addr until if_ack
// - if_addr    in   ADDR_W  IF byte address
// - if_ack     out  1       IF grant/data-valid strobe, one cycle
// - if_inst    out  DATA_W  IF read data; valid only when if_ack
// - mem_req    in   1       MEM load request; held with mem_addr until mem_ack
// - mem_addr   in   ADDR_W  MEM byte address
// - mem_ack    out  1       MEM grant/data-valid strobe, one cycle
// - mem_data   out  DATA_W  MEM read data; valid only when mem_ack
// - flush      in   1       pipeline flush; cancels IF service
// - stallreq   out  1       to pipeline control: IF is waiting on the ROM
// - rom_ce     out  1       ROM chip enable
// - rom_addr   out  ADDR_W  ROM address
// - rom_inst   in   DATA_W  ROM read word (combinational from rom_ce/rom_addr)
// BEHAVIOUR
// - FSM states: IDLE, GNT_IF, GNT_MEM; state, addr_q registered; reset -> IDLE, addr_q=0.
// - Arbitration at each posedge, using requests eligible this cycle:
//   - mem_req eligible -> GNT_MEM, addr_q<=mem_addr.
//   - else if_req eligible and !flush -> GNT_IF, addr_q<=if_addr.
//   - else -> IDLE.
//   - MEM has strict priority: the older instruction must not stall behind the younger.
// - Eligibility: in GNT_x, x_req is the request being served, so it is ineligible for the next decision. The other requester stays eligible.
// - Consequences of eligibility: one requester is served at most every 2nd cycle; contested requests alternate MEM, IF, MEM, IF...; neither side can starve.
// - Latency: req first high in cycle N (state IDLE) -> ack in cycle N+1.
// - GNT_x cycle:
//   - rom_ce=1, rom_addr=addr_q.
//   - x_ack=1; x_inst/x_data = rom_inst, combinational pass-through.
// - Outside grants: rom_ce=0, rom_addr=0, both acks 0, both data outputs = 32'h0 (ZeroWord).
// - Byte order: data passes unmodified; the ROM already returns the correctly ordered word. addr[1:0] passes through untouched.
// - stallreq = if_req & ~if_ack & ~flush (combinational).
// - flush:
//   - flush in GNT_IF cycle: if_ack forced 0, if_inst=0, rom_ce stays 1 (harmless); IF request dropped.
//   - flush in IDLE or GNT_MEM: IF is not granted at that edge.
//   - flush never affects MEM service.
// - Simultaneous mem_req & if_req while in GNT_MEM: IF wins (mem ineligible).
// - Requests arriving in IDLE with flush=1: only MEM is considered.
// - Reset mid-grant: at the rst edge, state -> IDLE. The next cycle drives all outputs to the values above. No ack is emitted for the aborted grant; requesters re-present their requests.
// CONFIGURATION
// - ROM_ARB_PERF_EN defined: adds perf_if_wait (out, 32) and perf_mem_gnt (out, 32).
//   - perf_if_wait: count of cycles with stallreq=1.
//   - perf_mem_gnt: count of GNT_MEM cycles.
//   - Both saturate at 32'hFFFFFFFF; rst clears to 0.
// - ROM_ARB_PERF_EN undefined: those ports and counters do not exist; arbitration identical.
// TESTING
// - Single IF: if_req=1, if_addr=12'h004 in IDLE -> next cycle rom_ce=1, rom_addr=12'h004, if_ack=1, if_inst=rom_inst; stallreq=1 for 1 cycle only.
// - Contention: if_req & mem_req together (0x010 / 0x020) -> cycle N+1 mem_ack with rom_addr=0x020; N+2 if_ack with rom_addr=0x010.
// - Continuous requests: both reqs held high 10 cycles -> acks alternate MEM/IF each cycle, never two acks in one cycle.
// - Flush: flush=1 during GNT_IF -> if_ack=0, if_inst=0, stallreq=0; next cycle IDLE; new if_req served one cycle later.
// - Reset: rst=1 during GNT_MEM -> following cycle rom_ce=0, mem_ack=0, mem_data=0, rom_addr=0, state IDLE.
// - Perf (ROM_ARB_PERF_EN): 3 contested IF/MEM pairs -> perf_mem_gnt=3, perf_if_wait=6; with macro undefined the build has no perf ports.

Source files
------------

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: pipeline/ROM bus shared with rom_arbiter.
// master = pipeline + ROM side, slave = arbiter side.
interface rom_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_inst;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_data;
    logic              flush;
    logic              stallreq;
    logic              rom_ce;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_inst;

    modport master (
        output if_req, if_addr, mem_req, mem_addr, flush, rom_inst,
        input  if_ack, if_inst, mem_ack, mem_data, stallreq, rom_ce, rom_addr
    );

    modport slave (
        input  if_req, if_addr, mem_req, mem_addr, flush, rom_inst,
        output if_ack, if_inst, mem_ack, mem_data, stallreq, rom_ce, rom_addr
    );
endinterface

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one combinational instruction ROM between IF fetch
// and MEM loads. One grant per cycle, data returned in the grant cycle,
// MEM has priority, the requester just served sits out the next decision.
// Optional macro ROM_ARB_PERF_EN adds saturating perf counters
// (o_perf_if_wait, o_perf_mem_gnt).
module rom_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    rom_arbiter_if.slave bus
`ifdef ROM_ARB_PERF_EN
    ,
    output logic [31:0] o_perf_if_wait,
    output logic [31:0] o_perf_mem_gnt
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_IF  = 2'd1,
        GNT_MEM = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr_q;
    logic              r_gnt_if;
    logic              r_gnt_mem;

    logic w_mem_elig;
    logic w_if_elig;
    logic w_grant;
    logic w_if_ack;
    logic w_stallreq;

    // The request being served this cycle is still held high; it must not
    // win the next decision, otherwise one side could monopolise the ROM.
    always_comb begin
        w_mem_elig = bus.mem_req & (r_state != GNT_MEM);
        w_if_elig  = bus.if_req  & (r_state != GNT_IF);
    end

    // Arbitration FSM: MEM first (older instruction), then IF unless flushed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_addr_q  <= '0;
            r_gnt_if  <= 1'b0;
            r_gnt_mem <= 1'b0;
        end else if (w_mem_elig) begin
            r_state   <= GNT_MEM;
            r_addr_q  <= bus.mem_addr;
            r_gnt_if  <= 1'b0;
            r_gnt_mem <= 1'b1;
        end else if (w_if_elig && !bus.flush) begin
            r_state   <= GNT_IF;
            r_addr_q  <= bus.if_addr;
            r_gnt_if  <= 1'b1;
            r_gnt_mem <= 1'b0;
        end else begin
            r_state   <= IDLE;
            r_gnt_if  <= 1'b0;
            r_gnt_mem <= 1'b0;
        end
    end

    // A flush landing on an IF grant kills the ack but leaves the ROM read
    // running; the wasted access has no side effects.
    always_comb begin
        w_grant    = r_gnt_if | r_gnt_mem;
        w_if_ack   = r_gnt_if & ~bus.flush;
        w_stallreq = bus.if_req & ~w_if_ack & ~bus.flush;
    end

    assign bus.rom_ce   = w_grant;
    assign bus.rom_addr = w_grant ? r_addr_q : '0;
    assign bus.if_ack   = w_if_ack;
    assign bus.if_inst  = w_if_ack ? bus.rom_inst : '0;
    assign bus.mem_ack  = r_gnt_mem;
    assign bus.mem_data = r_gnt_mem ? bus.rom_inst : '0;
    assign bus.stallreq = w_stallreq;

`ifdef ROM_ARB_PERF_EN
    logic [31:0] r_perf_if_wait;
    logic [31:0] r_perf_mem_gnt;

    // Saturating perf counters: IF stall cycles and MEM grant cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_perf_if_wait <= '0;
            r_perf_mem_gnt <= '0;
        end else begin
            if (w_stallreq && (r_perf_if_wait != 32'hFFFF_FFFF))
                r_perf_if_wait <= r_perf_if_wait + 32'd1;
            if (r_gnt_mem && (r_perf_mem_gnt != 32'hFFFF_FFFF))
                r_perf_mem_gnt <= r_perf_mem_gnt + 32'd1;
        end
    end

    assign o_perf_if_wait = r_perf_if_wait;
    assign o_perf_mem_gnt = r_perf_mem_gnt;
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: scripted requesters plus a scoreboard. Every request
// pushes its expected ROM address/word; each ack pops and compares.
module tb_rom_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    logic mon_en = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

`ifdef ROM_ARB_PERF_EN
    logic [31:0] perf_if_wait;
    logic [31:0] perf_mem_gnt;
`endif

    rom_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
`ifdef ROM_ARB_PERF_EN
        ,
        .o_perf_if_wait (perf_if_wait),
        .o_perf_mem_gnt (perf_mem_gnt)
`endif
    );

    // ROM model: distinct nonzero word for every address
    function automatic logic [31:0] rom_word(input logic [11:0] a);
        return {8'hC3, a, ~a};
    endfunction

    assign bus.rom_inst = rom_word(bus.rom_addr);

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t if_q[$];
    exp_t mem_q[$];
    exp_t mon_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic push_if(input logic [11:0] a);
        if_q.push_back('{a, rom_word(a)});
    endtask

    task automatic push_mem(input logic [11:0] a);
        mem_q.push_back('{a, rom_word(a)});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (mon_en) begin
            chk("one_ack", 32'(bus.if_ack & bus.mem_ack), 32'd0);
            if (bus.if_ack) begin
                chk("if_q_nonempty", 32'(if_q.size() != 0), 32'd1);
                if (if_q.size() != 0) begin
                    mon_e = if_q.pop_front();
                    chk("if_rom_addr", 32'(bus.rom_addr), 32'(mon_e.addr));
                    chk("if_inst", bus.if_inst, mon_e.data);
                end
            end else begin
                chk("if_inst_zero", bus.if_inst, 32'd0);
            end
            if (bus.mem_ack) begin
                chk("mem_q_nonempty", 32'(mem_q.size() != 0), 32'd1);
                if (mem_q.size() != 0) begin
                    mon_e = mem_q.pop_front();
                    chk("mem_rom_addr", 32'(bus.rom_addr), 32'(mon_e.addr));
                    chk("mem_data", bus.mem_data, mon_e.data);
                end
            end else begin
                chk("mem_data_zero", bus.mem_data, 32'd0);
            end
        end
    end

    // Both request together from IDLE: MEM next cycle, IF the cycle after
    task automatic contested_pair(input logic [11:0] ia, input logic [11:0] ma);
        bus.if_req = 1'b1;  bus.if_addr  = ia;
        bus.mem_req = 1'b1; bus.mem_addr = ma;
        push_if(ia);
        push_mem(ma);
        @(negedge clk);
        chk("cp_stall0", 32'(bus.stallreq), 32'd1);
        chk("cp_ce0", 32'(bus.rom_ce), 32'd0);
        step;
        @(negedge clk);
        chk("cp_mem_ack", 32'(bus.mem_ack), 32'd1);
        chk("cp_mem_addr", 32'(bus.rom_addr), 32'(ma));
        chk("cp_stall1", 32'(bus.stallreq), 32'd1);
        step;
        bus.mem_req = 1'b0;
        @(negedge clk);
        chk("cp_if_ack", 32'(bus.if_ack), 32'd1);
        chk("cp_if_addr", 32'(bus.rom_addr), 32'(ia));
        chk("cp_stall2", 32'(bus.stallreq), 32'd0);
        step;
        bus.if_req = 1'b0;
        @(negedge clk);
        chk("cp_idle_ce", 32'(bus.rom_ce), 32'd0);
        step;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.if_req = 1'b0;  bus.if_addr  = '0;
        bus.mem_req = 1'b0; bus.mem_addr = '0;
        bus.flush = 1'b0;
        step;
        step;
        mon_en = 1'b1;
        // reset state
        @(negedge clk);
        chk("rst_ce", 32'(bus.rom_ce), 32'd0);
        chk("rst_addr", 32'(bus.rom_addr), 32'd0);
        chk("rst_if_ack", 32'(bus.if_ack), 32'd0);
        chk("rst_mem_ack", 32'(bus.mem_ack), 32'd0);
        chk("rst_stall", 32'(bus.stallreq), 32'd0);
`ifdef ROM_ARB_PERF_EN
        chk("rst_perf_wait", perf_if_wait, 32'd0);
        chk("rst_perf_gnt", perf_mem_gnt, 32'd0);
`endif
        step;
        rst = 1'b0;
        @(negedge clk);
        step;

        // single IF fetch
        bus.if_req = 1'b1; bus.if_addr = 12'h004;
        push_if(12'h004);
        @(negedge clk);
        chk("sif_stall_n", 32'(bus.stallreq), 32'd1);
        chk("sif_ack_n", 32'(bus.if_ack), 32'd0);
        step;
        @(negedge clk);
        chk("sif_ack", 32'(bus.if_ack), 32'd1);
        chk("sif_ce", 32'(bus.rom_ce), 32'd1);
        chk("sif_addr", 32'(bus.rom_addr), 32'h004);
        chk("sif_stall", 32'(bus.stallreq), 32'd0);
        step;
        bus.if_req = 1'b0;
        @(negedge clk);
        chk("sif_done_ce", 32'(bus.rom_ce), 32'd0);
        chk("sif_done_stall", 32'(bus.stallreq), 32'd0);
        step;

        // contention
        contested_pair(12'h010, 12'h020);

        // continuous requests: strict alternation MEM, IF, MEM ...
        bus.mem_req = 1'b1; bus.mem_addr = 12'h100;
        bus.if_req  = 1'b1; bus.if_addr  = 12'h200;
        for (int i = 0; i < 6; i++) push_mem(12'h100);
        for (int i = 0; i < 5; i++) push_if(12'h200);
        @(negedge clk);
        step;
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) bus.if_req = 1'b0;
            @(negedge clk);
            chk("cont_mem", 32'(bus.mem_ack), 32'(k % 2));
            chk("cont_if", 32'(bus.if_ack), 32'((k % 2) == 0));
            step;
        end
        bus.mem_req = 1'b0;
        @(negedge clk);
        chk("cont_end_ce", 32'(bus.rom_ce), 32'd0);
        step;

        // flush during GNT_IF
        bus.if_req = 1'b1; bus.if_addr = 12'h040;
        @(negedge clk);
        step;
        bus.flush = 1'b1;
        @(negedge clk);
        chk("fl_ack", 32'(bus.if_ack), 32'd0);
        chk("fl_inst", bus.if_inst, 32'd0);
        chk("fl_stall", 32'(bus.stallreq), 32'd0);
        chk("fl_ce", 32'(bus.rom_ce), 32'd1);
        step;
        bus.flush = 1'b0; bus.if_addr = 12'h044;
        push_if(12'h044);
        @(negedge clk);
        chk("fl_idle_ce", 32'(bus.rom_ce), 32'd0);
        chk("fl_idle_stall", 32'(bus.stallreq), 32'd1);
        step;
        @(negedge clk);
        chk("fl_new_ack", 32'(bus.if_ack), 32'd1);
        chk("fl_new_addr", 32'(bus.rom_addr), 32'h044);
        step;
        bus.if_req = 1'b0;
        @(negedge clk);
        step;

        // flush in IDLE blocks the IF grant at that edge
        bus.if_req = 1'b1; bus.if_addr = 12'h050; bus.flush = 1'b1;
        push_if(12'h050);
        @(negedge clk);
        chk("fi_stall0", 32'(bus.stallreq), 32'd0);
        step;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("fi_ce", 32'(bus.rom_ce), 32'd0);
        chk("fi_stall1", 32'(bus.stallreq), 32'd1);
        step;
        @(negedge clk);
        chk("fi_ack", 32'(bus.if_ack), 32'd1);
        step;
        bus.if_req = 1'b0;
        @(negedge clk);
        step;

        // flush never affects MEM
        bus.mem_req = 1'b1; bus.mem_addr = 12'h060; bus.flush = 1'b1;
        push_mem(12'h060);
        @(negedge clk);
        step;
        @(negedge clk);
        chk("fm_mem_ack", 32'(bus.mem_ack), 32'd1);
        chk("fm_addr", 32'(bus.rom_addr), 32'h060);
        step;
        bus.mem_req = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        step;

        // reset during GNT_MEM: pending IF must not be granted at the rst edge
        bus.mem_req = 1'b1; bus.mem_addr = 12'h080;
        push_mem(12'h080);
        @(negedge clk);
        step;
        rst = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 12'h090;
        push_if(12'h090);
        @(negedge clk);
        step;
        rst = 1'b0; bus.mem_req = 1'b0;
        @(negedge clk);
        chk("rs_ce", 32'(bus.rom_ce), 32'd0);
        chk("rs_addr", 32'(bus.rom_addr), 32'd0);
        chk("rs_mem_ack", 32'(bus.mem_ack), 32'd0);
        chk("rs_mem_data", bus.mem_data, 32'd0);
        chk("rs_if_ack", 32'(bus.if_ack), 32'd0);
        step;
        @(negedge clk);
        chk("rs_if_ack2", 32'(bus.if_ack), 32'd1);
        chk("rs_if_addr", 32'(bus.rom_addr), 32'h090);
        step;
        bus.if_req = 1'b0;
        @(negedge clk);
        step;

`ifdef ROM_ARB_PERF_EN
        rst = 1'b1;
        @(negedge clk);
        step;
        rst = 1'b0;
        @(negedge clk);
        chk("perf_clr_wait", perf_if_wait, 32'd0);
        chk("perf_clr_gnt", perf_mem_gnt, 32'd0);
        step;
        contested_pair(12'h300, 12'h304);
        contested_pair(12'h308, 12'h30C);
        contested_pair(12'h310, 12'h314);
        @(negedge clk);
        chk("perf_mem_gnt", perf_mem_gnt, 32'd3);
        chk("perf_if_wait", perf_if_wait, 32'd6);
        step;
`endif

        mon_en = 1'b0;
        chk("if_q_empty", 32'(if_q.size()), 32'd0);
        chk("mem_q_empty", 32'(mem_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
